// File: rtl/fetch_ctrl_if.sv
// Instruction-memory req/ack bus between fetch_ctrl and the I-cache.
// master = fetch side, slave = memory side.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, one-entry decode buffer, redirects, HALT.
// Optional miss-wait counter enabled by defining FETCH_PERF_EN.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redir_valid,
  input  logic [15:0] redir_pc,
  fetch_ctrl_if.master imem,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic [15:0] wait_cycles
);

  typedef enum logic [1:0] {
    S_REQ,
    S_DRAIN,
    S_HALT
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [15:0] pend_pc_q;
  logic        pend_q;
  logic [15:0] instr_q;
  logic [15:0] instr_pc_q;
  logic        valid_q;
  logic        halted_q;
  logic        is_halt;

  assign is_halt = (imem.imem_rdata[15:11] == 5'b00000);
  assign pc_d    = pc_q + PC_INC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= 16'h0000;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem.imem_ack) begin
            pend_q <= 1'b0;
            if (redir_valid) begin
              pc_q <= redir_pc;
            end else if (pend_q) begin
              pc_q <= pend_pc_q;
            end else begin
              instr_q    <= imem.imem_rdata;
              instr_pc_q <= pc_q;
              valid_q    <= 1'b1;
              if (is_halt) begin
                halted_q <= 1'b1;
                state_q  <= S_HALT;
              end else begin
                pc_q    <= pc_d;
                state_q <= S_DRAIN;
              end
            end
          end else if (redir_valid) begin
            // Redirect mid-miss: keep addr stable, retarget after ack
            pend_q    <= 1'b1;
            pend_pc_q <= redir_pc;
          end
        end
        S_DRAIN: begin
          if (redir_valid) begin
            valid_q <= 1'b0;
            pc_q    <= redir_pc;
            state_q <= S_REQ;
          end else if (!stall_i) begin
            valid_q <= 1'b0;
            state_q <= S_REQ;
          end
        end
        S_HALT: begin
          if (!stall_i) valid_q <= 1'b0;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign imem.imem_req  = rst & (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign pc_plus2       = instr_pc_q + PC_INC;
  assign halted         = halted_q;

`ifdef FETCH_PERF_EN
  logic [15:0] wait_q;
  logic [15:0] wait_d;

  always_comb begin
    wait_d = wait_q;
    if (wait_q != 16'hFFFF) wait_d = wait_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= 16'h0000;
    end else if (state_q == S_REQ && !imem.imem_ack) begin
      wait_q <= wait_d;
    end
  end

  assign wait_cycles = wait_q;
`else
  assign wait_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle check against a fetch model
// plus literal expectations at key points of each scenario.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        redir_valid = 1'b0;
  logic [15:0] redir_pc = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        halted;
  logic [15:0] wait_cycles;

  int nvec = 0;
  int nerr = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .imem        (bus.master),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus2    (pc_plus2),
    .halted      (halted),
    .wait_cycles (wait_cycles)
  );

  always #5 clk = ~clk;

  // Fetch model: either fetching at m_pc, holding one instruction, or halted
  logic [15:0] m_pc = 16'h0000;
  logic        m_have = 1'b0;
  logic [15:0] m_instr = 16'h0000;
  logic [15:0] m_ipc = 16'h0000;
  logic        m_halt = 1'b0;
  logic        m_pend = 1'b0;
  logic [15:0] m_pend_pc = 16'h0000;
  logic [15:0] m_wait = 16'h0000;

  task automatic m_reset();
    m_pc = 16'h0000; m_have = 1'b0; m_instr = 16'h0000;
    m_ipc = 16'h0000; m_halt = 1'b0; m_pend = 1'b0;
    m_pend_pc = 16'h0000; m_wait = 16'h0000;
  endtask

  task automatic m_step();
    if (m_halt) begin
      if (m_have && !stall_i) m_have = 1'b0;
    end else if (m_have) begin
      if (redir_valid) begin
        m_have = 1'b0;
        m_pc = redir_pc;
      end else if (!stall_i) begin
        m_have = 1'b0;
      end
    end else if (bus.imem_ack) begin
      if (redir_valid) begin
        m_pc = redir_pc; m_pend = 1'b0;
      end else if (m_pend) begin
        m_pc = m_pend_pc; m_pend = 1'b0;
      end else begin
        m_have = 1'b1;
        m_instr = bus.imem_rdata;
        m_ipc = m_pc;
        if (bus.imem_rdata[15:11] == 5'd0) m_halt = 1'b1;
        else m_pc = m_pc + 16'd2;
      end
    end else begin
`ifdef FETCH_PERF_EN
      if (m_wait != 16'hFFFF) m_wait = m_wait + 16'd1;
`endif
      if (redir_valid) begin
        m_pend = 1'b1; m_pend_pc = redir_pc;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else m_step();
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk1("m_req", bus.imem_req, rst && !m_halt && !m_have);
    if (rst) begin
      if (!m_halt && !m_have) chk("m_addr", bus.imem_addr, m_pc);
      chk1("m_valid", instr_valid, m_have);
      if (m_have) begin
        chk("m_instr", instr, m_instr);
        chk("m_ipc", instr_pc, m_ipc);
        chk("m_pc2", pc_plus2, m_ipc + 16'd2);
      end
      chk1("m_halted", halted, m_halt);
      chk("m_wait", wait_cycles, m_wait);
    end
  end

  task automatic drv(input logic r, input logic [15:0] rp, input logic a,
                     input logic [15:0] rd, input logic s);
    redir_valid = r;
    redir_pc = rp;
    bus.imem_ack = a;
    bus.imem_rdata = rd;
    stall_i = s;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step(2);
    chk1("rst_req", bus.imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);

    // 1: ack on first req cycle
    rst = 1'b1;
    drv(1'b0, 16'h0, 1'b1, 16'h4001, 1'b0);
    #1;
    chk1("t1_req", bus.imem_req, 1'b1);
    chk("t1_addr", bus.imem_addr, 16'h0000);
    step(1);
    drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk1("t1_valid", instr_valid, 1'b1);
    chk("t1_instr", instr, 16'h4001);
    chk("t1_ipc", instr_pc, 16'h0000);
    chk("t1_pc2", pc_plus2, 16'h0002);
    chk1("t1_drain_req", bus.imem_req, 1'b0);
    step(1);
    chk1("t1_req2", bus.imem_req, 1'b1);
    chk("t1_addr2", bus.imem_addr, 16'h0002);

    // 2: ack after 3 wait cycles
    step(3);
    chk("t2_addr_held", bus.imem_addr, 16'h0002);
    drv(1'b0, 16'h0, 1'b1, 16'h4002, 1'b0);
    step(1);
    drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("t2_ipc", instr_pc, 16'h0002);
`ifdef FETCH_PERF_EN
    chk("t2_wait", wait_cycles, 16'd3);
`else
    chk("t2_wait", wait_cycles, 16'd0);
`endif
    step(1);

    // 3: redirect one cycle before ack
    drv(1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
    step(1);
    chk("t3_addr_hold", bus.imem_addr, 16'h0004);
    drv(1'b0, 16'h0, 1'b1, 16'h4003, 1'b0);
    step(1);
    drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk1("t3_valid", instr_valid, 1'b0);
    chk("t3_addr", bus.imem_addr, 16'h0100);

    // 4: stall in drain, then redirect under stall
    drv(1'b0, 16'h0, 1'b1, 16'h4004, 1'b1);
    step(1);
    drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    step(5);
    chk("t4_instr", instr, 16'h4004);
    chk("t4_ipc", instr_pc, 16'h0100);
    chk1("t4_req", bus.imem_req, 1'b0);
    drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step(1);
    chk1("t4_req2", bus.imem_req, 1'b1);
    chk("t4_addr2", bus.imem_addr, 16'h0102);
    drv(1'b0, 16'h0, 1'b1, 16'h4005, 1'b1);
    step(1);
    drv(1'b1, 16'h0020, 1'b0, 16'h0, 1'b1);
    step(1);
    chk1("t4_squash", instr_valid, 1'b0);
    chk("t4_redir", bus.imem_addr, 16'h0020);

    // pending redirect consumed by a later plain ack
    drv(1'b1, 16'h0040, 1'b0, 16'h0, 1'b0);
    step(1);
    drv(1'b0, 16'h0, 1'b1, 16'h4444, 1'b0);
    step(1);
    chk("pend_addr", bus.imem_addr, 16'h0040);
    chk1("pend_valid", instr_valid, 1'b0);
    drv(1'b1, 16'h0020, 1'b1, 16'h4555, 1'b0);
    step(1);
    chk("ackredir_addr", bus.imem_addr, 16'h0020);

    // 5: HALT at 0x0020
    drv(1'b0, 16'h0, 1'b1, 16'h0000, 1'b1);
    step(1);
    drv(1'b1, 16'h0300, 1'b0, 16'h0, 1'b1);
    step(2);
    chk1("t5_halted", halted, 1'b1);
    chk1("t5_valid", instr_valid, 1'b1);
    chk("t5_ipc", instr_pc, 16'h0020);
    chk1("t5_req", bus.imem_req, 1'b0);
    drv(1'b1, 16'h0300, 1'b0, 16'h0, 1'b0);
    step(1);
    drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step(2);
    chk1("t5_halted2", halted, 1'b1);
    chk1("t5_valid2", instr_valid, 1'b0);
    chk1("t5_req2", bus.imem_req, 1'b0);

    // 6: reset out of HALT, then PC wrap at 0xFFFE
    rst = 1'b0;
    #1;
    chk1("t6_rst_halted", halted, 1'b0);
    chk1("t6_rst_req", bus.imem_req, 1'b0);
    step(1);
    rst = 1'b1;
    drv(1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b0);
    step(1);
    chk("t6_hold", bus.imem_addr, 16'h0000);
    drv(1'b0, 16'h0, 1'b1, 16'h4AAA, 1'b0);
    step(1);
    chk("t6_addr", bus.imem_addr, 16'hFFFE);
    drv(1'b0, 16'h0, 1'b1, 16'h4006, 1'b1);
    step(1);
    chk("t6_ipc", instr_pc, 16'hFFFE);
    chk("t6_pc2", pc_plus2, 16'h0000);
    drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step(1);
    chk("t6_wrap", bus.imem_addr, 16'h0000);

    // reset mid-miss drops req at once
    step(2);
    rst = 1'b0;
    #1;
    chk1("rst_mid_req", bus.imem_req, 1'b0);
    step(1);
    rst = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
